decoding_block: RTL
===================

DECODING_BLOCK -- requirements
Module: decoding_block

Interface
REQ-001 SHALL have one clock and synchronous active-low reset: dec_clk (all logic on rising edge) and rst (sampled on dec_clk only; 0 = reset).
REQ-002 SHALL have ports, clock and reset first:
- dec_clk in 1: clock.
- rst in 1: synchronous active-low reset.
- enable in 1: block enable; 0 acts as soft reset.
- gen_speed in 2: 2 = 64b/66b; 1 = 128b/132b; 0 = raw byte pass-through.
- sym_valid in 1: lane symbols present this cycle.
- lane_0_rx_enc in 132: lane 0 encoded symbol.
- lane_1_rx_enc in 132: lane 1 encoded symbol.
- sym_ready out 1: symbol is accepted this cycle if sym_valid=1.
- lane_0_rx out 8: decoded lane 0 byte.
- lane_1_rx out 8: decoded lane 1 byte.
- rx_valid out 1: lane_x_rx valid.
- os_flag out 1: current byte belongs to an ordered-set symbol.
- hdr_err out 1: one-cycle pulse, symbol rejected for its header.
- overrun out 1: one-cycle pulse, symbol dropped while busy.
- err_cnt out 8: saturating count of hdr_err events.

Function
REQ-003 Byte count SHALL be N = 8 for gen_speed 2 and N = 16 for gen_speed 1.
REQ-004 Header field SHALL be bits [65:64] for gen_speed 2 and bits [131:128] for gen_speed 1.
REQ-005 Header codes SHALL be: data = 2'b10 / 4'b1010; ordered set = 2'b01 / 4'b0101.
REQ-006 State machine SHALL have states IDLE and DRAIN.
REQ-007 Accept = sym_valid && sym_ready; sym_ready SHALL be combinational: 1 in IDLE, or in DRAIN when byte_idx == N-1.
REQ-008 On accept, both lane headers SHALL be valid codes of the same type, else the symbol is rejected.
REQ-009 On a valid accept, both symbols SHALL be latched, gen_speed latched, os latched (1 if ordered-set code), byte_idx = 0, state -> DRAIN.
REQ-010 On a rejected accept: hdr_err = 1 next cycle, err_cnt += 1 (saturating at 255), symbol discarded, state and byte_idx take their non-accept values.
REQ-011 In DRAIN, every cycle SHALL register lane_x_rx = latched symbol bits [8*byte_idx+7 : 8*byte_idx], rx_valid = 1, os_flag = latched os, then byte_idx += 1.
REQ-012 Byte 0 (bits [7:0]) SHALL be output first; the first byte appears on the cycle after accept (latency 1).
REQ-013 At byte_idx == N-1: a valid accept in the same cycle SHALL reload and stay in DRAIN, giving gapless output; otherwise state -> IDLE.
REQ-014 When in IDLE with no drain, rx_valid SHALL be 0; lane_x_rx and os_flag SHALL hold their last values.
REQ-015 sym_valid with sym_ready = 0 SHALL pulse overrun the next cycle and drop the symbol; the drain in progress is unaffected.
REQ-016 gen_speed changes during DRAIN SHALL be ignored until the next accept.
REQ-017 gen_speed 0: every sym_valid cycle SHALL register lane_x_rx = lane_x_rx_enc[7:0] and rx_valid = 1 next cycle, with no header check, os_flag = 0, sym_ready = 1, and no overrun.
REQ-018 gen_speed 3 SHALL be treated as 0.
REQ-019 hdr_err and overrun SHALL never be asserted for more than one cycle per event.

Reset
REQ-020 rst = 0 at a rising edge SHALL set state IDLE, byte_idx = 0, lane_0_rx = lane_1_rx = 0, rx_valid = 0, os_flag = 0, hdr_err = 0, overrun = 0, err_cnt = 0, and clear the symbol registers.
REQ-021 enable = 0 SHALL have the same effect as rst = 0, except err_cnt holds.
REQ-022 Reset or disable asserted mid-drain SHALL abort the drain; no further bytes are output.

Verification
REQ-023 gen_speed = 2, lane 0 = {2'b10, 64'h0807060504030201}, one sym_valid -> bytes 01..08 on the following 8 cycles, rx_valid = 1 throughout, os_flag = 0, then rx_valid = 0.
REQ-024 gen_speed = 1, two back-to-back symbols with headers 4'b0101 then 4'b1010 -> 32 consecutive rx_valid cycles; os_flag = 1 for the first 16 and 0 for the next 16.
REQ-025 gen_speed = 2, lane 0 header 2'b10 with lane 1 header 2'b01 (or either header 2'b11) -> hdr_err pulses once, err_cnt = 1, no rx_valid.
REQ-026 gen_speed = 2, second sym_valid at drain byte 3 -> overrun pulses once, and the original 8 bytes complete intact.
REQ-027 rst = 0 at drain byte 5 -> all outputs at reset values the next cycle, and no further rx_valid.
REQ-028 300 bad-header symbols -> err_cnt saturates at 255; enable = 0 leaves it at 255.

Source files
------------

// File: rtl/decoding_block.sv
// Two-lane 64b/66b and 128b/132b symbol decoder: validates lane headers, then
// drains each accepted symbol one byte per cycle per lane (byte 0 first).
module decoding_block (
    input  logic         dec_clk,
    input  logic         rst,
    input  logic         enable,
    input  logic [1:0]   gen_speed,
    input  logic         sym_valid,
    input  logic [131:0] lane_0_rx_enc,
    input  logic [131:0] lane_1_rx_enc,
    output logic         sym_ready,
    output logic [7:0]   lane_0_rx,
    output logic [7:0]   lane_1_rx,
    output logic         rx_valid,
    output logic         os_flag,
    output logic         hdr_err,
    output logic         overrun,
    output logic [7:0]   err_cnt
);

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t         state, state_n;
    logic [3:0]     byte_idx, byte_idx_n;
    logic [127:0]   sym0_q, sym0_n, sym1_q, sym1_n;
    logic           spd16_q, spd16_n;
    logic           os_q, os_n;
    logic [7:0]     lane_0_n, lane_1_n, err_cnt_n;
    logic           rx_valid_n, os_flag_n, hdr_err_n, overrun_n;

    logic           raw, spd16_in, last, accept;
    logic           hdr_data, hdr_os;
    logic [6:0]     bit_ofs;

    always_comb begin
        raw      = (gen_speed == 2'd0) || (gen_speed == 2'd3);
        spd16_in = (gen_speed == 2'd1);
        last     = (state == DRAIN) && (byte_idx == (spd16_q ? 4'd15 : 4'd7));
        // A raw-mode symbol cannot be merged into the final drain byte, so it
        // is only taken while idle.
        sym_ready = (state == IDLE) || (last && !raw);
        accept    = sym_valid && sym_ready;
        bit_ofs   = {byte_idx, 3'b000};
        if (spd16_in) begin
            hdr_data = (lane_0_rx_enc[131:128] == 4'b1010) && (lane_1_rx_enc[131:128] == 4'b1010);
            hdr_os   = (lane_0_rx_enc[131:128] == 4'b0101) && (lane_1_rx_enc[131:128] == 4'b0101);
        end else begin
            hdr_data = (lane_0_rx_enc[65:64] == 2'b10) && (lane_1_rx_enc[65:64] == 2'b10);
            hdr_os   = (lane_0_rx_enc[65:64] == 2'b01) && (lane_1_rx_enc[65:64] == 2'b01);
        end
    end

    always_comb begin
        state_n    = state;
        byte_idx_n = byte_idx;
        sym0_n     = sym0_q;
        sym1_n     = sym1_q;
        spd16_n    = spd16_q;
        os_n       = os_q;
        lane_0_n   = lane_0_rx;
        lane_1_n   = lane_1_rx;
        rx_valid_n = 1'b0;
        os_flag_n  = os_flag;
        hdr_err_n  = 1'b0;
        overrun_n  = 1'b0;
        err_cnt_n  = err_cnt;

        if (state == DRAIN) begin
            lane_0_n   = sym0_q[bit_ofs +: 8];
            lane_1_n   = sym1_q[bit_ofs +: 8];
            rx_valid_n = 1'b1;
            os_flag_n  = os_q;
            if (last) begin
                state_n    = IDLE;
                byte_idx_n = '0;
            end else begin
                byte_idx_n = byte_idx + 4'd1;
            end
        end

        if (sym_valid && !sym_ready)
            overrun_n = 1'b1;

        if (accept) begin
            if (raw) begin
                lane_0_n   = lane_0_rx_enc[7:0];
                lane_1_n   = lane_1_rx_enc[7:0];
                rx_valid_n = 1'b1;
                os_flag_n  = 1'b0;
            end else if (hdr_data || hdr_os) begin
                sym0_n     = lane_0_rx_enc[127:0];
                sym1_n     = lane_1_rx_enc[127:0];
                spd16_n    = spd16_in;
                os_n       = hdr_os;
                byte_idx_n = '0;
                state_n    = DRAIN;
            end else begin
                hdr_err_n = 1'b1;
                if (err_cnt != 8'hFF)
                    err_cnt_n = err_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge dec_clk) begin
        if (!rst || !enable) begin
            state     <= IDLE;
            byte_idx  <= '0;
            sym0_q    <= '0;
            sym1_q    <= '0;
            spd16_q   <= 1'b0;
            os_q      <= 1'b0;
            lane_0_rx <= '0;
            lane_1_rx <= '0;
            rx_valid  <= 1'b0;
            os_flag   <= 1'b0;
            hdr_err   <= 1'b0;
            overrun   <= 1'b0;
            err_cnt   <= rst ? err_cnt : '0;
        end else begin
            state     <= state_n;
            byte_idx  <= byte_idx_n;
            sym0_q    <= sym0_n;
            sym1_q    <= sym1_n;
            spd16_q   <= spd16_n;
            os_q      <= os_n;
            lane_0_rx <= lane_0_n;
            lane_1_rx <= lane_1_n;
            rx_valid  <= rx_valid_n;
            os_flag   <= os_flag_n;
            hdr_err   <= hdr_err_n;
            overrun   <= overrun_n;
            err_cnt   <= err_cnt_n;
        end
    end

endmodule
